ec_mac_scheduler: RTL
=====================

EC_MAC_SCHEDULER -- requirements
Module: ec_mac_scheduler

Interface
REQ-001 Parameter ROWS, default 8: number of type-3 error-compensation MAC rows in the column being sequenced.
REQ-002 Parameter CNT_W, default 8: width of the vector-length input and internal counters.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request a tile run; sampled only in IDLE.
REQ-006 k_len  in  CNT_W  number of activation vectors to stream; captured on an accepted start.
REQ-007 err_in  in  ROWS  per-row MAC error_out flags.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 w_load_en  out  1  weight-register load strobe for one row.
REQ-010 w_row_sel  out  $clog2(ROWS)  row addressed by w_load_en.
REQ-011 act_valid  out  1  activation vector presented to row 0 this cycle.
REQ-012 psum_valid  out  1  partial_sum_out at the column bottom is a result.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err_count  out  16  saturating total of error events in the current or last run.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN and DONE, one-hot or binary encoded.
REQ-016 IDLE->LOAD_W on start=1; the SHALL capture k_len and clear err_count in the same edge.
REQ-017 LOAD_W SHALL last exactly ROWS cycles, with w_load_en=1 and w_row_sel counting 0..ROWS-1.
REQ-018 LOAD_W->STREAM after row ROWS-1 if captured k_len>0; LOAD_W->DRAIN if k_len=0.
REQ-019 STREAM SHALL assert act_valid for exactly k_len non-stalled cycles, then go to DRAIN.
REQ-020 DRAIN SHALL last ROWS+1 cycles, covering the MAC input register plus the ROWS-deep skew.
REQ-021 psum_valid SHALL be asserted ROWS+1 cycles after each act_valid cycle, so it is high for exactly k_len cycles per run.
REQ-022 DRAIN->DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-023 The err_count update SHALL add popcount(err_in) every cycle in STREAM or DRAIN and saturate at 16'hFFFF.
REQ-024 err_count SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-025 start while busy=1 SHALL be ignored, with no queueing.
REQ-026 A k_len change after capture SHALL have no effect on the run in progress.
REQ-027 Counters SHALL be CNT_W bits wide with no wrap; k_len=2^CNT_W-1 SHALL complete correctly.

Reset
REQ-028 rst_n=0 SHALL force state IDLE and all outputs and counters to 0 immediately, including mid-run.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro EC_ERR_STALL_EN defined, any err_in bit high during STREAM SHALL stall one cycle.
REQ-031 During a stall cycle, act_valid=0 and the STREAM counter holds, giving the compensation pass a bubble.
REQ-032 Stall cycles SHALL shift the matching psum_valid slot, so the total psum_valid count stays k_len.
REQ-033 Without EC_ERR_STALL_EN, err_in SHALL affect only err_count, and STREAM length SHALL always be k_len.

Verification
REQ-034 ROWS=8, start with k_len=4, err_in=0 -> w_load_en for 8 cycles, act_valid for 4, psum_valid for 4, done on cycle 8+4+9+1=22, err_count=0.
REQ-035 start with k_len=0 -> LOAD_W 8 cycles, DRAIN 9 cycles, done pulse, act_valid and psum_valid never high.
REQ-036 err_in=8'h03 held during a 3-cycle STREAM and 9-cycle DRAIN -> err_count=24; a second start clears err_count to 0.
REQ-037 With EC_ERR_STALL_EN, k_len=4 and err_in=8'h01 on the 2nd STREAM cycle -> act_valid high 4 of 5 STREAM cycles and done one cycle later than REQ-034.
REQ-038 rst_n pulsed low in the 2nd STREAM cycle -> all outputs 0 asynchronously; a start after release runs a full, correct sequence.
REQ-039 start held high through a whole run -> a new run begins only from IDLE, and done pulses once per run.

Source files
------------

// File: rtl/ec_mac_scheduler.sv
// Sequencer for a column of type-3 error-compensation MAC rows: weight load, activation stream,
// skew drain, done. Optional macro EC_ERR_STALL_EN inserts a stream bubble on any row error.
module ec_mac_scheduler #(
  parameter int ROWS  = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        k_len,
  input  logic [ROWS-1:0]         err_in,
  output logic                    busy,
  output logic                    w_load_en,
  output logic [$clog2(ROWS)-1:0] w_row_sel,
  output logic                    act_valid,
  output logic                    psum_valid,
  output logic                    done,
  output logic [15:0]             err_count
);
  localparam int SEL_W = $clog2(ROWS);
  localparam int DRN_W = $clog2(ROWS + 1);
  localparam int POP_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_klen;
  logic [CNT_W-1:0]   r_scnt;
  logic [SEL_W-1:0]   r_row;
  logic [DRN_W-1:0]   r_dcnt;
  logic [ROWS:0]      r_pipe;
  logic [15:0]        r_err;
  logic               r_busy;
  logic               r_load;
  logic               r_done;
  logic               w_stall;
  logic               w_act;
  logic               w_row_last;
  logic [POP_W-1:0]   w_pop;
  logic [16:0]        w_err_sum;
  logic [15:0]        w_err_sat;

`ifdef EC_ERR_STALL_EN
  assign w_stall = (r_state == S_STREAM) && (|err_in);
`else
  assign w_stall = 1'b0;
`endif

  // act_valid reacts to err_in in the same cycle so a stall becomes a true bubble
  assign w_act      = (r_state == S_STREAM) && !w_stall;
  assign w_row_last = (r_row == SEL_W'(ROWS - 1));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_pop = w_pop + POP_W'(err_in[i]);
    end
  end

  assign w_err_sum = {1'b0, r_err} + 17'(w_pop);
  assign w_err_sat = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LOAD_W;
      S_LOAD_W: if (w_row_last) w_state_next = (r_klen != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_act && (r_scnt == r_klen - CNT_W'(1))) w_state_next = S_DRAIN;
      S_DRAIN:  if (r_dcnt == DRN_W'(ROWS)) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_scnt  <= '0;
      r_row   <= '0;
      r_dcnt  <= '0;
      r_pipe  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_load  <= (w_state_next == S_LOAD_W);
      r_done  <= (w_state_next == S_DONE);
      // one slot per stream cycle, so bubbles shift the matching psum slot too
      r_pipe  <= {r_pipe[ROWS-1:0], w_act};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_klen <= k_len;
            r_err  <= '0;
            r_row  <= '0;
          end
        end
        S_LOAD_W: begin
          r_row  <= w_row_last ? '0 : r_row + SEL_W'(1);
          r_scnt <= '0;
          r_dcnt <= '0;
        end
        S_STREAM: begin
          if (w_act) r_scnt <= r_scnt + CNT_W'(1);
          r_err <= w_err_sat;
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DRN_W'(1);
          r_err  <= w_err_sat;
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign w_load_en  = r_load;
  assign w_row_sel  = r_row;
  assign act_valid  = w_act;
  assign psum_valid = r_pipe[ROWS];
  assign done       = r_done;
  assign err_count  = r_err;
endmodule
